usb_out_ep_fifo: RTL and testbench
==================================

USB_OUT_EP_FIFO -- requirements
Module: usb_out_ep_fifo

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 64, byte capacity; power of two, 4..256.
REQ-002 The block SHALL have port clk, input, 1, sole clock; reset is synchronous, active-high, named reset.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port out_ep_req, output, 1, bus request to the OUT endpoint arbiter.
REQ-005 The block SHALL have port out_ep_grant, input, 1, arbiter grant; data_get is issued only while it is high.
REQ-006 The block SHALL have port out_ep_data_avail, input, 1, OUT protocol engine has an unread payload byte.
REQ-007 The block SHALL have port out_ep_setup, input, 1, current packet arrived with a SETUP token.
REQ-008 The block SHALL have port out_ep_data_get, output, 1, one-cycle read strobe to the protocol engine.
REQ-009 The block SHALL have port out_ep_data, input, 8, registered read data, valid the cycle after data_get.
REQ-010 The block SHALL have port out_ep_stall, output, 1, endpoint stall request, driven from stall_in.
REQ-011 The block SHALL have port stall_in, input, 1, core-side stall request.
REQ-012 The block SHALL have port rd_data, output, 8, FIFO head byte.
REQ-013 The block SHALL have port rd_valid, output, 1, FIFO non-empty.
REQ-014 The block SHALL have port rd_ready, input, 1, consumer accepts the head byte when high with rd_valid.
REQ-015 The block SHALL have port level, output, log2(FIFO_DEPTH)+1, current FIFO occupancy.

Function
REQ-016 The drain FSM SHALL have states IDLE, REQ, FETCH and CAPTURE.
REQ-017 IDLE SHALL go to REQ when out_ep_data_avail=1 and level<FIFO_DEPTH; otherwise it SHALL stay in IDLE.
REQ-018 out_ep_req SHALL be 1 in REQ, FETCH and CAPTURE, and 0 in IDLE.
REQ-019 REQ SHALL go to FETCH when out_ep_grant=1.
REQ-020 REQ SHALL return to IDLE when out_ep_data_avail=0.
REQ-021 FETCH SHALL assert out_ep_data_get for exactly one cycle and go to CAPTURE unconditionally.
REQ-022 CAPTURE SHALL write out_ep_data into the FIFO, subject to REQ-044.
REQ-023 From CAPTURE the FSM SHALL go to FETCH if out_ep_data_avail=1, out_ep_grant=1 and level after this cycle's write/read <FIFO_DEPTH; otherwise it SHALL go to IDLE.
REQ-024 Throughput SHALL be one byte per two cycles; the FSM SHALL never issue back-to-back data_get strobes.
REQ-025 Loss of grant during FETCH or CAPTURE SHALL NOT drop the in-flight byte; the FSM SHALL complete CAPTURE, then go to IDLE.
REQ-026 The FIFO SHALL be first-word-fall-through: rd_data is the head byte whenever rd_valid=1.
REQ-027 rd_data SHALL be don't-care when rd_valid=0.
REQ-028 A pop SHALL occur when rd_valid and rd_ready are both 1.
REQ-029 Read and write pointers SHALL be log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH.
REQ-030 Full SHALL be decoded as MSBs differing with the rest equal; empty SHALL be decoded as pointers equal.
REQ-031 A simultaneous push and pop SHALL leave level unchanged, including at level=FIFO_DEPTH and at level=1.
REQ-032 A pop while empty SHALL be ignored.
REQ-033 No write SHALL ever occur when full; REQ-017/REQ-023 guarantee this, and an assertion SHALL flag any violation.
REQ-034 out_ep_stall SHALL equal stall_in registered by one cycle.
REQ-035 out_ep_data_get SHALL be 0 when out_ep_grant=0.

Reset
REQ-036 On reset the FSM SHALL go to IDLE.
REQ-037 On reset both FIFO pointers SHALL be cleared to 0.
REQ-038 On reset, out_ep_req, out_ep_data_get, out_ep_stall, rd_valid and level SHALL be 0.
REQ-039 On reset rd_data SHALL be 0.
REQ-040 Reset during FETCH or CAPTURE SHALL discard the in-flight byte without a FIFO write.
REQ-041 FIFO storage SHALL NOT be cleared by reset.

Configuration
REQ-042 Macro USB_OUT_FIFO_SETUP_FILTER_EN SHALL select SETUP-packet filtering.
REQ-043 Without USB_OUT_FIFO_SETUP_FILTER_EN, SETUP and OUT payload bytes SHALL be written identically.
REQ-044 With USB_OUT_FIFO_SETUP_FILTER_EN, a byte captured while out_ep_setup=1 SHALL still be drained by data_get but SHALL NOT be written to the FIFO.
REQ-045 With USB_OUT_FIFO_SETUP_FILTER_EN, the FIFO full check SHALL NOT block draining while out_ep_setup=1.

Verification
REQ-046 Scenario: avail=1 for 4 bytes 0x11,0x22,0x33,0x44, grant=1, rd_ready=1 -> 4 data_get pulses 2 cycles apart, rd_data sequence 11,22,33,44, level ends at 0.
REQ-047 Scenario: FIFO_DEPTH=4, rd_ready=0, 6 bytes available -> exactly 4 data_get pulses, level=4, req=0; raise rd_ready -> remaining 2 bytes drained, order preserved.
REQ-048 Scenario: grant drops in the cycle after data_get -> byte still written, FSM to IDLE, req=0, no further data_get until grant returns.
REQ-049 Scenario: level=FIFO_DEPTH with push and pop in the same cycle -> level stays FIFO_DEPTH, no overwrite; 200 bytes streamed through depth 64 -> pointer wrap, data intact.
REQ-050 Scenario: reset asserted during CAPTURE -> no write, level=0, all outputs 0 next cycle.
REQ-051 Scenario: with USB_OUT_FIFO_SETUP_FILTER_EN, an 8-byte SETUP then a 2-byte OUT -> 10 data_get pulses, level=2.
REQ-052 Scenario: same stimulus as REQ-051 without USB_OUT_FIFO_SETUP_FILTER_EN -> level=10.

Source files
------------

// File: rtl/usb_out_ep_fifo.sv
// usb_out_ep_fifo
//   Drains payload bytes from the USB OUT protocol engine into a
//   first-word-fall-through byte FIFO for the core-side consumer.
//
//   Optional feature macro: USB_OUT_FIFO_SETUP_FILTER_EN
//     When defined, bytes captured while out_ep_setup=1 are still drained
//     from the engine but are not stored, and the full check does not
//     hold off draining while out_ep_setup=1.
//
// Parameters
//   FIFO_DEPTH         byte capacity, power of two, 4..256
//
// Ports
//   clk                sole clock
//   reset              synchronous, active-high reset
//   out_ep_req         bus request to the OUT endpoint arbiter
//   out_ep_grant       arbiter grant
//   out_ep_data_avail  engine holds an unread payload byte
//   out_ep_setup       current packet arrived with a SETUP token
//   out_ep_data_get    one-cycle read strobe to the engine
//   out_ep_data        engine read data, valid the cycle after data_get
//   out_ep_stall       stall request to the endpoint (stall_in, registered)
//   stall_in           core-side stall request
//   rd_data            FIFO head byte (0 while empty)
//   rd_valid           FIFO non-empty
//   rd_ready           consumer accepts the head byte
//   level              FIFO occupancy
module usb_out_ep_fifo #(
   parameter int unsigned FIFO_DEPTH = 64
) (
   input  logic                          clk,
   input  logic                          reset,
   output logic                          out_ep_req,
   input  logic                          out_ep_grant,
   input  logic                          out_ep_data_avail,
   input  logic                          out_ep_setup,
   output logic                          out_ep_data_get,
   input  logic [7:0]                    out_ep_data,
   output logic                          out_ep_stall,
   input  logic                          stall_in,
   output logic [7:0]                    rd_data,
   output logic                          rd_valid,
   input  logic                          rd_ready,
   output logic [$clog2(FIFO_DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_LEVEL = {1'b1, {AW{1'b0}}};

   typedef enum logic [1:0] {IDLE, REQ, FETCH, CAPTURE} state_t;

   state_t      state, state_nxt;
   logic [AW:0] wr_ptr, rd_ptr, level_nxt;
   logic [7:0]  mem [FIFO_DEPTH];
   logic        full, empty, push, pop;
   logic        fetched;
   logic        drop;
   logic        room_idle, room_capture;

`ifdef USB_OUT_FIFO_SETUP_FILTER_EN
   assign drop = out_ep_setup;
`else
   logic unused_setup;
   assign unused_setup = out_ep_setup;
   assign drop         = 1'b0;
`endif

   // Pointer-based FIFO status
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level    = wr_ptr - rd_ptr;
   assign rd_valid = !empty;
   assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
   assign pop      = rd_valid && rd_ready;

   // A byte is only stored if its strobe was actually issued in FETCH;
   // a FETCH cycle without grant produces no strobe and nothing to capture.
   assign push      = (state == CAPTURE) && fetched && !drop;
   assign level_nxt = level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

   assign room_idle    = !full || drop;
   assign room_capture = (level_nxt != FULL_LEVEL) || drop;

   always_comb begin
      state_nxt       = state;
      out_ep_req      = (state != IDLE);
      out_ep_data_get = 1'b0;
      case (state)
         IDLE: begin
            if (out_ep_data_avail && room_idle)
               state_nxt = REQ;
         end
         REQ: begin
            if (!out_ep_data_avail)
               state_nxt = IDLE;
            else if (out_ep_grant)
               state_nxt = FETCH;
         end
         FETCH: begin
            out_ep_data_get = out_ep_grant;
            state_nxt       = CAPTURE;
         end
         CAPTURE: begin
            if (out_ep_data_avail && out_ep_grant && room_capture)
               state_nxt = FETCH;
            else
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         fetched      <= 1'b0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         out_ep_stall <= 1'b0;
      end else begin
         state        <= state_nxt;
         fetched      <= out_ep_data_get;
         out_ep_stall <= stall_in;
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage is not reset; the write is gated so a reset during CAPTURE
   // drops the in-flight byte.
   always_ff @(posedge clk) begin
      if (push && !reset)
         mem[wr_ptr[AW-1:0]] <= out_ep_data;
   end

   assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: tb/tb_usb_out_ep_fifo.sv
module tb_usb_out_ep_fifo;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned LW    = $clog2(DEPTH) + 1;
`ifdef USB_OUT_FIFO_SETUP_FILTER_EN
   localparam int SETUP_LEVEL = 2;
`else
   localparam int SETUP_LEVEL = 10;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          out_ep_req, out_ep_data_get, out_ep_stall, rd_valid;
   logic          out_ep_grant = 1'b0;
   logic          out_ep_setup = 1'b0;
   logic          out_ep_data_avail;
   logic          stall_in = 1'b1;
   logic          rd_ready = 1'b0;
   logic [7:0]    out_ep_data = '0;
   logic [7:0]    rd_data;
   logic [LW-1:0] level;

   always #5 clk = ~clk;

   usb_out_ep_fifo #(.FIFO_DEPTH(DEPTH)) dut (
      .clk               (clk),
      .reset             (reset),
      .out_ep_req        (out_ep_req),
      .out_ep_grant      (out_ep_grant),
      .out_ep_data_avail (out_ep_data_avail),
      .out_ep_setup      (out_ep_setup),
      .out_ep_data_get   (out_ep_data_get),
      .out_ep_data       (out_ep_data),
      .out_ep_stall      (out_ep_stall),
      .stall_in          (stall_in),
      .rd_data           (rd_data),
      .rd_valid          (rd_valid),
      .rd_ready          (rd_ready),
      .level             (level)
   );

   // Protocol engine model: a byte queue read by data_get, data registered.
   logic [7:0] eng_mem [1024];
   int         eng_wr = 0;
   int         eng_rd = 0;
   logic       hide = 1'b0;
   int         get_cnt = 0;
   int         cyc = 0;
   int         bb_err = 0;
   logic       prev_get = 1'b0;
   int         get_cyc [1024];

   assign out_ep_data_avail = (eng_rd != eng_wr) && !hide;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      prev_get <= out_ep_data_get;
      if (out_ep_data_get) begin
         out_ep_data               <= eng_mem[eng_rd % 1024];
         eng_rd                    <= eng_rd + 1;
         get_cyc[get_cnt % 1024]   <= cyc;
         get_cnt                   <= get_cnt + 1;
         if (prev_get)
            bb_err <= bb_err + 1;
      end
   end

   int max_level = 0;
   int gnt_err = 0;
   always @(negedge clk) begin
      if (int'(level) > max_level)
         max_level = int'(level);
      if (out_ep_data_get && !out_ep_grant)
         gnt_err = gnt_err + 1;
   end

   logic [7:0] exp_q [$];
   int total = 0;
   int bad = 0;
   int pop_cnt = 0;
   int bno = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic pop_check();
      if (rd_valid && rd_ready) begin
         if (exp_q.size() == 0)
            chk("pop_unexpected", exp_q.size(), 1);
         else begin
            chk("pop_data", int'(rd_data), int'(exp_q[0]));
            exp_q.delete(0);
            pop_cnt++;
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      pop_check();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [7:0] b);
      eng_mem[eng_wr % 1024] = b;
      eng_wr++;
`ifdef USB_OUT_FIFO_SETUP_FILTER_EN
      if (!out_ep_setup)
         exp_q.push_back(b);
`else
      exp_q.push_back(b);
`endif
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while ((out_ep_req || eng_rd != eng_wr) && n < budget) begin
         step();
         n++;
      end
      chk(name, int'(out_ep_req || eng_rd != eng_wr), 0);
   endtask

   task automatic wait_drained(input string name, input int budget);
      int n = 0;
      while ((out_ep_req || eng_rd != eng_wr || rd_valid) && n < budget) begin
         step();
         n++;
      end
      chk(name, int'(out_ep_req || eng_rd != eng_wr || rd_valid), 0);
   endtask

   task automatic wait_strobe(input string name, input int budget);
      int n = 0;
      while (!out_ep_data_get && n < budget) begin
         step();
         n++;
      end
      chk(name, int'(out_ep_data_get), 1);
   endtask

   task automatic wait_gets(input string name, input int target, input int budget);
      int n = 0;
      while (get_cnt < target && n < budget) begin
         step();
         n++;
      end
      chk(name, get_cnt, target);
   endtask

   // Simultaneous push and pop at occupancy n: level must not move.
   task automatic push_pop_at(input int n);
      rd_ready     = 1'b0;
      out_ep_grant = 1'b1;
      for (int i = 0; i < n; i++) begin
         load(8'(8'h60 + i));
      end
      wait_idle("pp_fill", 200);
      chk($sformatf("pp%0d_level_before", n), int'(level), n);
      load(8'h9C);
      wait_strobe("pp_strobe", 20);
      step();                       // now in CAPTURE
      rd_ready = 1'b1;
      step();                       // push and pop on the same edge
      rd_ready = 1'b0;
      chk($sformatf("pp%0d_level_after", n), int'(level), n);
      rd_ready = 1'b1;
      wait_drained("pp_drain", 200);
   endtask

   typedef struct {
      int   load;
      logic grant;
      logic stall;
      logic hide;
      logic e_req;
      logic e_get;
      logic e_stall;
      int   e_level;
   } vec_t;

   vec_t tv [25];

   initial begin
      int base;
      int pbase;

      //            load g  st hd | req get stl lvl
      tv = '{
         '{0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0},
         '{1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0},
         '{0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0},
         '{0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0},
         '{0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0},
         '{0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0},
         '{0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0},
         '{0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1},
         '{0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1},
         '{0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1},
         '{1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1},
         '{0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1},
         '{0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1},
         '{0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1},
         '{0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1},
         '{0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1},
         '{0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1},
         '{0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1},
         '{0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2},
         '{1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2},
         '{0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2},
         '{0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2},
         '{0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2},
         '{0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2},
         '{0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2}
      };

      // Reset state (stall_in held high to show reset wins)
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req",     int'(out_ep_req), 0);
      chk("rst_get",     int'(out_ep_data_get), 0);
      chk("rst_stall",   int'(out_ep_stall), 0);
      chk("rst_valid",   int'(rd_valid), 0);
      chk("rst_level",   int'(level), 0);
      chk("rst_rd_data", int'(rd_data), 0);
      reset    = 1'b0;
      stall_in = 1'b0;

      // Cycle-by-cycle handshake, stall path, REQ abort, FETCH without grant
      for (int i = 0; i < 25; i++) begin
         for (int k = 0; k < tv[i].load; k++) begin
            load(8'(8'hA0 + bno));
            bno++;
         end
         out_ep_grant = tv[i].grant;
         stall_in     = tv[i].stall;
         hide         = tv[i].hide;
         @(negedge clk);
         chk($sformatf("v%0d_req", i),   int'(out_ep_req),      int'(tv[i].e_req));
         chk($sformatf("v%0d_get", i),   int'(out_ep_data_get), int'(tv[i].e_get));
         chk($sformatf("v%0d_stall", i), int'(out_ep_stall),    int'(tv[i].e_stall));
         chk($sformatf("v%0d_level", i), int'(level),           tv[i].e_level);
         pop_check();
         @(posedge clk);
         #1;
      end

      // Four-byte stream with consumer ready: strobes two cycles apart
      out_ep_grant = 1'b1;
      rd_ready     = 1'b1;
      base = get_cnt;
      load(8'h11); load(8'h22); load(8'h33); load(8'h44);
      wait_drained("stream4_drain", 100);
      chk("stream4_gets", get_cnt, base + 5);
      chk("stream4_span", get_cyc[(base + 4) % 1024] - get_cyc[(base + 1) % 1024], 6);
      chk("stream4_level", int'(level), 0);
      chk("stream4_q", exp_q.size(), 0);

      // Fill to full with consumer stalled, then release
      rd_ready = 1'b0;
      base = get_cnt;
      for (int i = 0; i < DEPTH + 2; i++) begin
         load(8'(8'h50 + i));
      end
      wait_gets("fill_gets", base + DEPTH, 100);
      repeat (4) step();
      chk("fill_gets_held", get_cnt, base + DEPTH);
      chk("fill_level", int'(level), DEPTH);
      chk("fill_req", int'(out_ep_req), 0);
      chk("fill_valid", int'(rd_valid), 1);
      rd_ready = 1'b1;
      wait_drained("fill_drain", 200);
      chk("fill_gets_all", get_cnt, base + DEPTH + 2);

      push_pop_at(1);
      push_pop_at(DEPTH - 1);

      // Grant lost in CAPTURE: byte still stored, FSM back to IDLE
      rd_ready     = 1'b0;
      out_ep_grant = 1'b1;
      base = get_cnt;
      load(8'h71); load(8'h72);
      wait_strobe("gdrop_strobe", 20);
      step();
      out_ep_grant = 1'b0;
      @(negedge clk);
      chk("gdrop_cap_req", int'(out_ep_req), 1);
      chk("gdrop_cap_get", int'(out_ep_data_get), 0);
      @(posedge clk);
      #1;
      chk("gdrop_idle_req", int'(out_ep_req), 0);
      chk("gdrop_level", int'(level), 1);
      repeat (5) step();
      chk("gdrop_no_get", get_cnt, base + 1);
      out_ep_grant = 1'b1;
      wait_idle("gdrop_resume", 50);
      chk("gdrop_gets", get_cnt, base + 2);
      chk("gdrop_level2", int'(level), 2);
      rd_ready = 1'b1;
      wait_drained("gdrop_drain", 50);

      // Reset during CAPTURE discards the in-flight byte and the FIFO
      rd_ready = 1'b0;
      load(8'h81);
      wait_idle("rstcap_pre", 50);
      load(8'h82);
      wait_strobe("rstcap_strobe", 20);
      step();
      reset    = 1'b1;
      stall_in = 1'b1;
      @(posedge clk);
      #1;
      chk("rstcap_level", int'(level), 0);
      chk("rstcap_req",   int'(out_ep_req), 0);
      chk("rstcap_get",   int'(out_ep_data_get), 0);
      chk("rstcap_valid", int'(rd_valid), 0);
      chk("rstcap_data",  int'(rd_data), 0);
      chk("rstcap_stall", int'(out_ep_stall), 0);
      reset    = 1'b0;
      stall_in = 1'b0;
      exp_q.delete();
      repeat (3) step();
      chk("rstcap_level_after", int'(level), 0);

      // SETUP packet followed by an OUT packet
      out_ep_grant = 1'b1;
      base = get_cnt;
      out_ep_setup = 1'b1;
      for (int i = 0; i < 8; i++) begin
         load(8'(8'hC0 + i));
      end
      wait_idle("setup_drain", 100);
      out_ep_setup = 1'b0;
      load(8'hD0); load(8'hD1);
      wait_idle("out_drain", 50);
      chk("setup_gets", get_cnt, base + 10);
      chk("setup_level", int'(level), SETUP_LEVEL);
      rd_ready = 1'b1;
      wait_drained("setup_pop", 100);

      // 200 bytes through the FIFO with an irregular consumer
      out_ep_grant = 1'b1;
      base  = get_cnt;
      pbase = pop_cnt;
      for (int i = 0; i < 200; i++) begin
         load(8'(i * 7 + 3));
      end
      begin
         int n = 0;
         while ((out_ep_req || eng_rd != eng_wr || rd_valid) && n < 3000) begin
            rd_ready = ($urandom_range(0, 3) != 0);
            step();
            n++;
         end
         chk("wrap_done", int'(out_ep_req || eng_rd != eng_wr || rd_valid), 0);
      end
      rd_ready = 1'b1;
      chk("wrap_gets", get_cnt, base + 200);
      chk("wrap_pops", pop_cnt, pbase + 200);
      chk("wrap_level", int'(level), 0);

      // Run-wide properties
      chk("no_back_to_back_get", bb_err, 0);
      chk("no_get_without_grant", gnt_err, 0);
      chk("level_bounded", int'(max_level <= DEPTH), 1);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
